axi_stream_zero_padder: RTL and testbench



---
 rtl/axi_stream_zero_padder.sv | 136 +++++++++++++
 tb/tb_axi_stream_zero_padder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_zero_padder.sv
// Zero-padding front end for the strip-ordered convolver: wraps each column strip
// in zero top/bottom rows and zero left/right border columns, one 4-pixel word per beat.
module axi_stream_zero_padder #(
  parameter int IMAGE_HEIGHT = 12,
  parameter int NUM_STRIPS   = 2,
  parameter int NB_PIXEL     = 8,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset_n,
  input  logic                  s_axis_valid,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  output logic                  s_axis_ready,
  output logic                  m_axis_valid,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  input  logic                  m_axis_ready,
  output logic                  m_axis_last,
  output logic [1:0]            o_dbg_state
);

  localparam int RW = $clog2(IMAGE_HEIGHT);
  localparam int SW = (NUM_STRIPS > 1) ? $clog2(NUM_STRIPS) : 1;
  localparam logic [RW-1:0] ROW_BODY_LAST = RW'(IMAGE_HEIGHT - 2);
  localparam logic [SW-1:0] STRIP_LAST    = SW'(NUM_STRIPS - 1);

  typedef enum logic [1:0] {
    ST_TOP    = 2'd0,
    ST_BODY   = 2'd1,
    ST_BOTTOM = 2'd2
  } state_t;

  state_t                r_state;
  logic [SW-1:0]         r_strip_cnt;
  logic [RW-1:0]         r_row_cnt;
  logic                  r_m_valid;
  logic                  r_m_last;
  logic [DATA_WIDTH-1:0] r_m_data;

  state_t                w_state_nxt;
  logic [SW-1:0]         w_strip_nxt;
  logic [RW-1:0]         w_row_nxt;
  logic                  w_valid_nxt;
  logic                  w_last_nxt;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic [DATA_WIDTH-1:0] w_body_data;
  logic                  w_load_en;
  logic                  w_accept;

  // Handshakes: a beat/word moves on a rising edge only when its valid and ready are
  // both high in that cycle; valid never waits on ready, and upstream ready depends
  // only on state and downstream ready (never on s_axis_valid).
  assign w_load_en    = !r_m_valid || m_axis_ready;
  assign s_axis_ready = (r_state == ST_BODY) && w_load_en;
  assign w_accept     = s_axis_valid && s_axis_ready;

  // The outer strips carry only three real columns; the fourth lane becomes the border.
  always_comb begin
    w_body_data = s_axis_data;
    if (r_strip_cnt == '0) begin
      w_body_data = {s_axis_data[3*NB_PIXEL-1:0], {NB_PIXEL{1'b0}}};
    end else if (r_strip_cnt == STRIP_LAST) begin
      w_body_data = {{NB_PIXEL{1'b0}}, s_axis_data[3*NB_PIXEL-1:0]};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_strip_nxt = r_strip_cnt;
    w_row_nxt   = r_row_cnt;
    w_valid_nxt = r_m_valid;
    w_last_nxt  = r_m_last;
    w_data_nxt  = r_m_data;
    case (r_state)
      ST_TOP: begin
        if (w_load_en) begin
          w_valid_nxt = 1'b1;
          w_last_nxt  = 1'b0;
          w_data_nxt  = '0;
          w_row_nxt   = RW'(1);
          w_state_nxt = ST_BODY;
        end
      end
      ST_BODY: begin
        if (w_accept) begin
          w_valid_nxt = 1'b1;
          w_last_nxt  = 1'b0;
          w_data_nxt  = w_body_data;
          w_row_nxt   = r_row_cnt + RW'(1);
          if (r_row_cnt == ROW_BODY_LAST) begin
            w_state_nxt = ST_BOTTOM;
          end
        end else if (w_load_en) begin
          // Upstream gap: let the register drain rather than repeat a word.
          w_valid_nxt = 1'b0;
        end
      end
      ST_BOTTOM: begin
        if (w_load_en) begin
          w_valid_nxt = 1'b1;
          w_data_nxt  = '0;
          w_row_nxt   = '0;
          w_state_nxt = ST_TOP;
          w_last_nxt  = (r_strip_cnt == STRIP_LAST);
          w_strip_nxt = (r_strip_cnt == STRIP_LAST) ? '0 : r_strip_cnt + SW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_TOP;
      end
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_state     <= ST_TOP;
      r_strip_cnt <= '0;
      r_row_cnt   <= '0;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
      r_m_data    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_strip_cnt <= w_strip_nxt;
      r_row_cnt   <= w_row_nxt;
      r_m_valid   <= w_valid_nxt;
      r_m_last    <= w_last_nxt;
      r_m_data    <= w_data_nxt;
    end
  end

  assign m_axis_valid = r_m_valid;
  assign m_axis_data  = r_m_data;
  assign m_axis_last  = r_m_last;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_axi_stream_zero_padder.sv
// Bench for axi_stream_zero_padder: frames built from a padded-image model, checked
// word by word under ready/valid patterns, plus a 3-strip lane-mapping table.
`timescale 1ns/1ps
module tb_axi_stream_zero_padder;

  localparam int A_H = 12;
  localparam int A_N = 2;
  localparam int B_H = 4;
  localparam int B_N = 3;
  localparam int NB  = 8;
  localparam int DW  = 32;
  localparam int A_WORDS = A_H * A_N;
  localparam int B_WORDS = B_H * B_N;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          a_s_valid, a_s_ready, a_m_valid, a_m_ready, a_m_last;
  logic [DW-1:0] a_s_data, a_m_data;
  logic [1:0]    a_dbg;
  logic          b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_m_last;
  logic [DW-1:0] b_s_data, b_m_data;
  logic [1:0]    b_dbg;

  axi_stream_zero_padder #(.IMAGE_HEIGHT(A_H), .NUM_STRIPS(A_N), .NB_PIXEL(NB), .DATA_WIDTH(DW)) u_dut_a (
    .axi_clk(clk), .axi_reset_n(rst_n),
    .s_axis_valid(a_s_valid), .s_axis_data(a_s_data), .s_axis_ready(a_s_ready),
    .m_axis_valid(a_m_valid), .m_axis_data(a_m_data), .m_axis_ready(a_m_ready),
    .m_axis_last(a_m_last), .o_dbg_state(a_dbg)
  );

  axi_stream_zero_padder #(.IMAGE_HEIGHT(B_H), .NUM_STRIPS(B_N), .NB_PIXEL(NB), .DATA_WIDTH(DW)) u_dut_b (
    .axi_clk(clk), .axi_reset_n(rst_n),
    .s_axis_valid(b_s_valid), .s_axis_data(b_s_data), .s_axis_ready(b_s_ready),
    .m_axis_valid(b_m_valid), .m_axis_data(b_m_data), .m_axis_ready(b_m_ready),
    .m_axis_last(b_m_last), .o_dbg_state(b_dbg)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] beat_q[$];
  logic [DW-1:0] exp_q[$];
  logic          exp_last_q[$];
  logic [DW-1:0] got_data[A_WORDS];
  logic          got_last[A_WORDS];

  bit            prev_stall;
  logic [DW-1:0] held_data;
  logic          held_last;

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        last;
  } spot_t;
  spot_t spots[8];

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
  } lane_vec_t;
  lane_vec_t b_vec[6];

  logic [DW-1:0] b_got[B_WORDS];
  logic          b_got_last[B_WORDS];
  logic [DW-1:0] b_exp[$];
  int bi, bg, bc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: the frame is a zero-bordered image; each strip is four padded columns.
  task automatic build_frame(input bit spec_img);
    logic [NB-1:0] pad[A_H][4*A_N];
    logic [DW-1:0] w;
    int col;
    for (int r = 0; r < A_H; r++)
      for (int c = 0; c < 4*A_N; c++) pad[r][c] = '0;
    for (int r = 0; r < A_H-2; r++)
      for (int c = 0; c < 4*A_N-2; c++)
        pad[r+1][c+1] = spec_img ? 8'(129 + 6*r + c) : 8'($urandom);
    for (int s = 0; s < A_N; s++)
      for (int r = 1; r <= A_H-2; r++) begin
        for (int k = 0; k < 4; k++) begin
          if (k == 3 && (s == 0 || s == A_N-1)) begin
            w[k*NB +: NB] = 8'($urandom);
          end else begin
            col = (s == 0) ? (1 + k) : (4*s + k);
            w[k*NB +: NB] = pad[r][col];
          end
        end
        beat_q.push_back(w);
      end
    for (int s = 0; s < A_N; s++)
      for (int r = 0; r < A_H; r++) begin
        for (int k = 0; k < 4; k++) w[k*NB +: NB] = pad[r][4*s+k];
        exp_q.push_back(w);
        exp_last_q.push_back(s == A_N-1 && r == A_H-1);
      end
  endtask

  task automatic run_frame(input int n_words, input bit rnd,
                           input logic [3:0] rdy_pat, input logic [3:0] vld_pat);
    int got = 0;
    int cyc = 0;
    bit hold = 0;
    logic [DW-1:0] e_data;
    logic e_last;
    prev_stall = 0;
    while (got < n_words && cyc < 2000) begin
      if (!hold) begin
        if (beat_q.size() > 0 && (rnd ? ($urandom_range(0, 1) == 1) : vld_pat[cyc%4])) begin
          a_s_valid = 1'b1;
          a_s_data  = beat_q[0];
        end else begin
          a_s_valid = 1'b0;
          a_s_data  = $urandom;
        end
      end
      a_m_ready = rnd ? ($urandom_range(0, 2) != 0) : rdy_pat[cyc%4];
      @(negedge clk);
      if (prev_stall)
        check("hold_stable", {a_m_valid, a_m_last, a_m_data}, {1'b1, held_last, held_data});
      if (a_m_valid && !a_m_ready) check("s_ready_in_stall", a_s_ready, 0);
      if (a_dbg != 2'd1) check("s_ready_outside_body", a_s_ready, 0);
      if (a_m_valid && a_m_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_word: got %h with nothing expected", a_m_data);
        end else begin
          e_data = exp_q.pop_front();
          e_last = exp_last_q.pop_front();
          check($sformatf("word%0d", got), {a_m_last, a_m_data}, {e_last, e_data});
        end
        got_data[got] = a_m_data;
        got_last[got] = a_m_last;
        got++;
      end
      prev_stall = a_m_valid && !a_m_ready;
      held_data  = a_m_data;
      held_last  = a_m_last;
      if (a_s_valid && a_s_ready) begin
        void'(beat_q.pop_front());
        hold = 0;
      end else begin
        hold = a_s_valid;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    if (got < n_words) check("frame_timeout", got, n_words);
    a_s_valid = 1'b0;
    a_m_ready = 1'b0;
  endtask

  task automatic check_spots();
    for (int i = 0; i < 8; i++)
      check($sformatf("spot_word%0d", spots[i].idx),
            {got_last[spots[i].idx], got_data[spots[i].idx]}, {spots[i].last, spots[i].data});
  endtask

  initial begin
    spots[0] = '{0,  32'h00000000, 1'b0};
    spots[1] = '{1,  32'h83828100, 1'b0};
    spots[2] = '{10, 32'hB9B8B700, 1'b0};
    spots[3] = '{11, 32'h00000000, 1'b0};
    spots[4] = '{12, 32'h00000000, 1'b0};
    spots[5] = '{13, 32'h00868584, 1'b0};
    spots[6] = '{22, 32'h00BCBBBA, 1'b0};
    spots[7] = '{23, 32'h00000000, 1'b1};
    b_vec[0] = '{32'hFF030201, 32'h03020100};
    b_vec[1] = '{32'h5A0C0B0A, 32'h0C0B0A00};
    b_vec[2] = '{32'h44332211, 32'h44332211};
    b_vec[3] = '{32'h88776655, 32'h88776655};
    b_vec[4] = '{32'hEE030201, 32'h00030201};
    b_vec[5] = '{32'h77F0E0D0, 32'h00F0E0D0};

    rst_n = 1'b0;
    a_s_valid = 1'b0; a_s_data = '0; a_m_ready = 1'b0;
    b_s_valid = 1'b0; b_s_data = '0; b_m_ready = 1'b0;

    // Reset: outputs quiet, then the TOP zero word appears while s_axis_ready stays low.
    repeat (3) @(posedge clk);
    a_m_ready = 1'b1;
    @(negedge clk);
    check("rst_m_valid", a_m_valid, 0);
    check("rst_m_last", a_m_last, 0);
    check("rst_m_data", a_m_data, 0);
    check("rst_s_ready", a_s_ready, 0);
    a_m_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_word_valid", a_m_valid, 1);
    check("first_word_data", a_m_data, 0);
    check("first_word_last", a_m_last, 0);
    check("first_s_ready", a_s_ready, 0);
    @(posedge clk);
    #1;
    check("first_s_ready_held", a_s_ready, 0);

    build_frame(1'b1);
    run_frame(A_WORDS, 1'b0, 4'b1111, 4'b1111);
    check("beats_left_full", beat_q.size(), 0);
    check_spots();

    build_frame(1'b1);
    run_frame(A_WORDS, 1'b0, 4'b1001, 4'b1111);
    check("beats_left_bp", beat_q.size(), 0);
    check_spots();

    build_frame(1'b1);
    run_frame(A_WORDS, 1'b0, 4'b1111, 4'b0001);
    check("beats_left_gaps", beat_q.size(), 0);
    check_spots();

    for (int f = 0; f < 3; f++) begin
      build_frame(1'b0);
      run_frame(A_WORDS, 1'b1, 4'b0000, 4'b0000);
      check("beats_left_rand", beat_q.size(), 0);
    end

    // Mid-frame reset after word 7: the partial frame is dropped.
    build_frame(1'b1);
    run_frame(8, 1'b0, 4'b1111, 4'b1111);
    beat_q.delete();
    exp_q.delete();
    exp_last_q.delete();
    rst_n = 1'b0;
    #1;
    check("midrst_m_valid", a_m_valid, 0);
    check("midrst_s_ready", a_s_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    build_frame(1'b1);
    run_frame(A_WORDS, 1'b0, 4'b1111, 4'b1111);
    check_spots();

    // Three-strip instance: first, middle and last lane mappings.
    bi = 0; bg = 0; bc = 0;
    b_m_ready = 1'b1;
    while (bg < B_WORDS && bc < 200) begin
      if (bi < 6) begin
        b_s_valid = 1'b1;
        b_s_data  = b_vec[bi].din;
      end else begin
        b_s_valid = 1'b0;
      end
      @(negedge clk);
      if (b_m_valid && b_m_ready) begin
        b_got[bg] = b_m_data;
        b_got_last[bg] = b_m_last;
        bg++;
      end
      if (b_s_valid && b_s_ready) bi++;
      @(posedge clk);
      #1;
      bc++;
    end
    if (bg < B_WORDS) check("b_timeout", bg, B_WORDS);
    for (int s = 0; s < B_N; s++) begin
      b_exp.push_back('0);
      b_exp.push_back(b_vec[2*s].dout);
      b_exp.push_back(b_vec[2*s+1].dout);
      b_exp.push_back('0);
    end
    for (int j = 0; j < bg; j++)
      check($sformatf("b_word%0d", j), {b_got_last[j], b_got[j]},
            {(j == B_WORDS-1), b_exp[j]});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
